// File: rtl/csa_nibble_sequencer_if.sv
// Request/result bundle between a requester and the nibble-serial adder.
// The requester drives start/operands; the sequencer returns busy/done/result.
interface csa_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/csa_nibble_sequencer.sv
// WIDTH-bit adder built from one shared 4-bit carry-select stage, one nibble per cycle, LSB first.
// Latency WIDTH/4 cycles from accepted start to done; start is ignored while busy, accepted in IDLE or DONE.
module csa_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  csa_nibble_sequencer_if.slave   bus
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             accept;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW+1:0]    idx;
  logic [4:0]       nib;
  logic             last;

  // 4-bit carry-select stage: low pair ripples, high pair is precomputed for both carries.
  function automatic logic [4:0] csa4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;
    lo  = {1'b0, x[1:0]} + {1'b0, y[1:0]} + {2'b00, ci};
    hi0 = {1'b0, x[3:2]} + {1'b0, y[3:2]};
    hi1 = hi0 + 3'd1;
    return lo[2] ? {hi1, lo[1:0]} : {hi0, lo[1:0]};
  endfunction

  assign idx  = {cnt, 2'b00};
  assign nib  = csa4(a_q[idx +: 4], b_q[idx +: 4], c_q);
  assign last = (cnt == CW'(N - 1));

  always_comb begin
    acc_nxt           = acc;
    acc_nxt[idx +: 4] = nib[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers load only on the final nibble so partial sums never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
      c_q <= bus.cin;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      c_q <= nib[4];
      if (last) begin
        sum_q   <= acc_nxt;
        carry_q <= nib[4];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_csa_nibble_sequencer.sv
// Bench for csa_nibble_sequencer: vector table, hand-written corner sequences and random
// traffic checked every cycle against a countdown/queue reference model.
module tb_csa_nibble_sequencer;

  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  csa_nibble_sequencer_if #(.WIDTH(W)) bus ();

  csa_nibble_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start books N busy cycles, then one done cycle with a+b+cin.
  int          busy_left   = 0;
  logic        done_m      = 1'b0;
  logic [W-1:0] sum_m      = '0;
  logic        carry_m     = 1'b0;
  logic [W:0]  pend        = '0;
  int          accepts     = 0;
  int          model_dones = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left = 0;
      done_m    = 1'b0;
      sum_m     = '0;
      carry_m   = 1'b0;
    end else begin
      done_m = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          done_m           = 1'b1;
          {carry_m, sum_m} = pend;
          model_dones++;
        end
      end else if (bus.start) begin
        pend      = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
        busy_left = N;
        accepts++;
      end
    end
  end

  int busy_run  = 0;
  int dut_dones = 0;

  always @(negedge clk) begin
    check("cyc_busy",  {31'd0, bus.busy},  {31'd0, busy_left > 0});
    check("cyc_done",  {31'd0, bus.done},  {31'd0, done_m});
    check("cyc_sum",   {16'd0, bus.sum},   {16'd0, sum_m});
    check("cyc_carry", {31'd0, bus.carry}, {31'd0, carry_m});
    if (!rst_n) begin
      busy_run = 0;
    end else if (bus.busy) begin
      busy_run++;
    end
    if (bus.done) begin
      dut_dones++;
      check("busy_len", busy_run, N);
      busy_run = 0;
    end
  end

  // Waits (bounded) for done, sampling on falling edges; returns busy cycles seen before it.
  task automatic wait_done(output logic found, output int nbusy);
    found = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1'b1;
        break;
      end
      if (bus.busy) nbusy++;
    end
    if (!found) check("done_timeout", 0, 1);
  endtask

  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic found;
    int   nb;
    int   target;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.start = 1'($urandom_range(0, 1));
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_sum",   {16'd0, bus.sum},   32'h0);
      check("rst_carry", {31'd0, bus.carry}, 32'h0);
      check("rst_busy",  {31'd0, bus.busy},  32'h0);
      check("rst_done",  {31'd0, bus.done},  32'h0);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      pulse_start(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(found, nb);
      check("tbl_busy_cycles", nb, N);
      check("tbl_sum",   {16'd0, bus.sum},   {16'd0, vecs[i].exp_sum});
      check("tbl_carry", {31'd0, bus.carry}, {31'd0, vecs[i].exp_carry});
      @(posedge clk); #1;
    end

    // Start during RUN is ignored; start during DONE is taken back-to-back.
    pulse_start(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    pulse_start(16'hAAAA, 16'h5555, 1'b0);
    wait_done(found, nb);
    check("ign_sum",   {16'd0, bus.sum},   32'h2345);
    check("ign_carry", {31'd0, bus.carry}, 32'h0);
    bus.a     = 16'h8000;
    bus.b     = 16'h8000;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(found, nb);
    check("b2b_busy_cycles", nb, N);
    check("b2b_sum",   {16'd0, bus.sum},   32'h0000);
    check("b2b_carry", {31'd0, bus.carry}, 32'h1);
    @(posedge clk); #1;

    // Reset mid-operation clears outputs at once and suppresses done.
    pulse_start(16'h0F0F, 16'h0101, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {31'd0, bus.busy},  32'h0);
    check("mid_rst_carry", {31'd0, bus.carry}, 32'h0);
    check("mid_rst_sum",   {16'd0, bus.sum},   32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", {31'd0, bus.done}, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_start(16'h0001, 16'h0001, 1'b0);
    wait_done(found, nb);
    check("post_rst_sum",   {16'd0, bus.sum},   32'h0002);
    check("post_rst_carry", {31'd0, bus.carry}, 32'h0);
    @(posedge clk); #1;

    // Random traffic: start toggles freely, including while busy.
    target = accepts + 200;
    for (int cyc = 0; cyc < 5000 && accepts < target; cyc++) begin
      bus.start = ($urandom_range(0, 2) != 0);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("rand_accepts", accepts, target);
    bus.start = 1'b0;
    repeat (2 * N + 2) begin
      @(posedge clk); #1;
    end
    check("done_count", dut_dones, model_dones);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
